// File: rtl/m_sel_arb_pkg.sv
// Shared encodings and small helpers for the round-robin select arbiter.
// Owner indices map to sources one..three; select codes follow the downstream mux encoding.
package m_sel_arb_pkg;

  typedef logic [1:0] owner_t;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [1:0] SEL_ONE   = 2'b01;
  localparam logic [1:0] SEL_TWO   = 2'b10;
  localparam logic [1:0] SEL_THREE = 2'b00;

  localparam owner_t OWN_ONE   = 2'd0;
  localparam owner_t OWN_TWO   = 2'd1;
  localparam owner_t OWN_THREE = 2'd2;

  // Next owner index in round-robin order, modulo three.
  function automatic owner_t rr_next(input owner_t idx);
    owner_t res;
    case (idx)
      OWN_ONE:   res = OWN_TWO;
      OWN_TWO:   res = OWN_THREE;
      OWN_THREE: res = OWN_ONE;
      default:   res = OWN_ONE;
    endcase
    return res;
  endfunction

  function automatic logic req_bit(input logic [2:0] req, input owner_t idx);
    logic res;
    case (idx)
      OWN_ONE:   res = req[0];
      OWN_TWO:   res = req[1];
      OWN_THREE: res = req[2];
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [1:0] sel_of(input owner_t idx);
    logic [1:0] res;
    case (idx)
      OWN_ONE:   res = SEL_ONE;
      OWN_TWO:   res = SEL_TWO;
      OWN_THREE: res = SEL_THREE;
      default:   res = SEL_THREE;
    endcase
    return res;
  endfunction

  function automatic logic [2:0] gnt_of(input owner_t idx);
    logic [2:0] res;
    case (idx)
      OWN_ONE:   res = 3'b001;
      OWN_TWO:   res = 3'b010;
      OWN_THREE: res = 3'b100;
      default:   res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/m_sel_arb_if.sv
// Request/select bundle between the request sources and the select arbiter.
interface m_sel_arb_if;
  logic [2:0] din_req;
  logic [1:0] dout_sel;
  logic [2:0] dout_gnt;
  logic       dout_valid;
  logic       dout_switch;

  modport master (
    output din_req,
    input  dout_sel,
    input  dout_gnt,
    input  dout_valid,
    input  dout_switch
  );

  modport slave (
    input  din_req,
    output dout_sel,
    output dout_gnt,
    output dout_valid,
    output dout_switch
  );
endinterface

// File: rtl/m_sel_arb_rr_pick.sv
// Combinational round-robin picker: scans start+1, start+2, then start itself
// unless excl_en drops the start index from the search.
module m_rr_pick
  import m_sel_arb_pkg::*;
(
  input  logic [2:0] req,
  input  owner_t     start,
  input  logic       excl_en,
  output owner_t     winner,
  output logic       found
);

  owner_t cand1_s;
  owner_t cand2_s;

  assign cand1_s = rr_next(start);
  assign cand2_s = rr_next(cand1_s);

  // Priority scan over the three candidates in round-robin order.
  always_comb begin
    winner = start;
    found  = 1'b0;
    if (req_bit(req, cand1_s)) begin
      winner = cand1_s;
      found  = 1'b1;
    end else if (req_bit(req, cand2_s)) begin
      winner = cand2_s;
      found  = 1'b1;
    end else if (!excl_en && req_bit(req, start)) begin
      winner = start;
      found  = 1'b1;
    end else begin
      winner = start;
      found  = 1'b0;
    end
  end

endmodule

// File: rtl/m_sel_arb.sv
// Registered round-robin select arbiter feeding the priority-select mux; each grant
// is held for at least HOLD_CYC cycles so the mux never glitches between sources.
module m_sel_arb
  import m_sel_arb_pkg::*;
#(
  parameter int HOLD_CYC = 4,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  m_sel_arb_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [0:0]       state_r;
  logic [0:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  owner_t           last_r;
  owner_t           last_nxt_s;
  owner_t           owner_r;
  owner_t           owner_nxt_s;
  logic             valid_nxt_s;
  logic             switch_nxt_s;

  logic [1:0]       sel_r;
  logic [2:0]       gnt_r;
  logic             valid_r;
  logic             switch_r;

  owner_t           pick_start_s;
  logic             pick_excl_s;
  owner_t           pick_win_s;
  logic             pick_found_s;

  // In GRANT the owner always equals the last pointer; excluding it lets others win first.
  assign pick_start_s = (state_r == ST_GRANT) ? owner_r : last_r;
  assign pick_excl_s  = (state_r == ST_GRANT);

  m_rr_pick u_pick (
    .req     (bus.din_req),
    .start   (pick_start_s),
    .excl_en (pick_excl_s),
    .winner  (pick_win_s),
    .found   (pick_found_s)
  );

  // Next-state decode for ownership, hold counter and output qualifiers.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    last_nxt_s   = last_r;
    owner_nxt_s  = owner_r;
    valid_nxt_s  = valid_r;
    switch_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_nxt_s  = ST_GRANT;
          cnt_nxt_s    = CNT_LOAD;
          owner_nxt_s  = pick_win_s;
          last_nxt_s   = pick_win_s;
          valid_nxt_s  = 1'b1;
          switch_nxt_s = 1'b1;
        end else begin
          valid_nxt_s  = 1'b0;
        end
      end
      ST_GRANT: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_nxt_s    = cnt_r - CNT_ONE;
        end else if (pick_found_s) begin
          cnt_nxt_s    = CNT_LOAD;
          owner_nxt_s  = pick_win_s;
          last_nxt_s   = pick_win_s;
          valid_nxt_s  = 1'b1;
          switch_nxt_s = 1'b1;
        end else if (req_bit(bus.din_req, owner_r)) begin
          cnt_nxt_s    = CNT_LOAD;
        end else begin
          state_nxt_s  = ST_IDLE;
          cnt_nxt_s    = CNT_ZERO;
          valid_nxt_s  = 1'b0;
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        cnt_nxt_s    = CNT_ZERO;
        valid_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, counter, pointer and registered mux-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      last_r   <= OWN_THREE;
      owner_r  <= OWN_THREE;
      sel_r    <= SEL_THREE;
      gnt_r    <= 3'b000;
      valid_r  <= 1'b0;
      switch_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      last_r   <= last_nxt_s;
      owner_r  <= owner_nxt_s;
      sel_r    <= valid_nxt_s ? sel_of(owner_nxt_s) : SEL_THREE;
      gnt_r    <= valid_nxt_s ? gnt_of(owner_nxt_s) : 3'b000;
      valid_r  <= valid_nxt_s;
      switch_r <= switch_nxt_s;
    end
  end

  assign bus.dout_sel    = sel_r;
  assign bus.dout_gnt    = gnt_r;
  assign bus.dout_valid  = valid_r;
  assign bus.dout_switch = switch_r;

endmodule

// File: tb/tb_m_sel_arb.sv
// Directed bench for m_sel_arb with HOLD_CYC=4; expected outputs are written per cycle.
module tb_m_sel_arb;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  m_sel_arb_if bus ();

  m_sel_arb #(.HOLD_CYC(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed word: {valid, gnt, sel, switch}
  function automatic logic [6:0] obs();
    return {bus.dout_valid, bus.dout_gnt, bus.dout_sel, bus.dout_switch};
  endfunction

  // Expected word from a grant pattern; sel follows the mux encoding.
  function automatic logic [6:0] ex(input logic [2:0] g, input logic sw);
    logic [1:0] s;
    case (g)
      3'b001:  s = 2'b01;
      3'b010:  s = 2'b10;
      default: s = 2'b00;
    endcase
    return {|g, g, s, sw};
  endfunction

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got={v,gnt,sel,sw}=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] g;
    n_tests = 0;
    n_fail  = 0;

    // 1. reset with all requests high, then release idle
    rst_n = 1'b0;
    bus.din_req = 3'b111;
    #1;
    chk("rst_async", obs(), ex(3'b000, 1'b0));
    repeat (3) tick();
    chk("rst_held", obs(), ex(3'b000, 1'b0));
    bus.din_req = 3'b000;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_idle", obs(), ex(3'b000, 1'b0));
    end

    // 2. single request held, then dropped at a re-arbitration edge
    bus.din_req = 3'b001;
    tick();
    chk("single_grant", obs(), ex(3'b001, 1'b1));
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("single_hold", obs(), ex(3'b001, 1'b0));
    end
    bus.din_req = 3'b000;
    tick();
    chk("single_release", obs(), ex(3'b000, 1'b0));

    // re-reset so source one has first priority again
    rst_n = 1'b0;
    #2;
    chk("rst_pulse", obs(), ex(3'b000, 1'b0));
    rst_n = 1'b1;

    // 3. full contention: 001 x4, 010 x4, 100 x4, then 001
    bus.din_req = 3'b111;
    for (int k = 0; k <= 12; k++) begin
      tick();
      g = 3'b001 << ((k / 4) % 3);
      chk("contend", obs(), ex(g, (k % 4) == 0));
    end
    bus.din_req = 3'b000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("contend_tail", obs(), ex(3'b001, 1'b0));
    end
    tick();
    chk("contend_idle", obs(), ex(3'b000, 1'b0));

    // 4. early drop: one-cycle request still held four cycles
    bus.din_req = 3'b010;
    tick();
    chk("drop_grant", obs(), ex(3'b010, 1'b1));
    bus.din_req = 3'b000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("drop_hold", obs(), ex(3'b010, 1'b0));
    end
    tick();
    chk("drop_idle", obs(), ex(3'b000, 1'b0));
    tick();
    chk("drop_idle2", obs(), ex(3'b000, 1'b0));

    // 5. sole persistent requester on source three
    bus.din_req = 3'b100;
    tick();
    chk("sole_grant", obs(), ex(3'b100, 1'b1));
    for (int k = 1; k < 20; k++) begin
      tick();
      chk("sole_hold", obs(), ex(3'b100, 1'b0));
    end

    // direct handover at the re-arbitration edge, no idle bubble
    bus.din_req = 3'b010;
    tick();
    chk("handover", obs(), ex(3'b010, 1'b1));
    tick();
    chk("handover_hold", obs(), ex(3'b010, 1'b0));

    // 6. async reset mid-grant, clears before the next edge
    rst_n = 1'b0;
    #1;
    chk("rst_mid", obs(), ex(3'b000, 1'b0));
    bus.din_req = 3'b111;
    #2;
    rst_n = 1'b1;
    tick();
    chk("rst_mid_first", obs(), ex(3'b001, 1'b1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
